// File: rtl/SB_codex_pkg.sv
// Sideband message header type shared by the SB_TX path and its producers.
package SB_codex_pkg;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  srcid;
        logic [2:0]  dstid;
        logic [7:0]  msgcode;
        logic [7:0]  msgsubcode;
        logic [15:0] msginfo;
    } SB_msg_t;

    // All-ones opcode marks "no message" so an idle header is distinguishable from a real one
    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m            = '{default: '0};
        m.opcode     = 5'h1F;
        return m;
    endfunction

endpackage

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing one SB_TX between NUM_REQ message producers.
// Optional macro SB_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module sb_tx_arbiter
    import SB_codex_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int DROP_TIMEOUT = 16
) (
    input  logic                   clk_100MHz,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*64-1:0]  req_data_i,
    input  SB_msg_t                req_msg_i [NUM_REQ],
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic                   send_next_flag_i,
    output logic [63:0]            dataBus_o,
    output SB_msg_t                SB_msg_o,
    output logic                   valid_o,
    output logic [2:0]             grant_id_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int         CNT_W  = (DROP_TIMEOUT > 2) ? $clog2(DROP_TIMEOUT) : 1;
    localparam logic [3:0] NREQ_W = 4'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DROP = 2'd2,
        WAIT_RDY  = 2'd3
    } state_t;

    state_t               state_r;
    logic [2:0]           rr_ptr_r;
    logic [CNT_W-1:0]     cnt_r;

    logic [15:0]          req_ext_s;
    logic [3:0]           sum_s;
    logic [3:0]           cand_s;
    logic [2:0]           win_id_s;
    logic [NUM_REQ-1:0]   win_onehot_s;
    logic [63:0]          win_data_s;
    SB_msg_t              win_msg_s;
    logic                 any_req_s;

    assign req_ext_s = 16'(req_valid_i);
    assign any_req_s = |req_valid_i;

    // Winner search: scan backwards so the slot nearest rr_ptr+1 is written last and wins
    always_comb begin
        win_id_s = 3'd0;
        sum_s    = 4'd0;
        cand_s   = 4'd0;
`ifdef SB_ARB_PRIO0_EN
        for (int i = NUM_REQ - 1; i >= 1; i--) begin
            sum_s    = {1'b0, rr_ptr_r} + 4'(i);
            cand_s   = (sum_s > (NREQ_W - 4'd1)) ? (sum_s - (NREQ_W - 4'd1)) : sum_s;
            win_id_s = req_ext_s[cand_s] ? cand_s[2:0] : win_id_s;
        end
        win_id_s = req_valid_i[0] ? 3'd0 : win_id_s;
`else
        for (int i = NUM_REQ; i >= 1; i--) begin
            sum_s    = {1'b0, rr_ptr_r} + 4'(i);
            cand_s   = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
            win_id_s = req_ext_s[cand_s] ? cand_s[2:0] : win_id_s;
        end
`endif
    end

    // Payload/header mux and one-hot accept vector for the selected winner
    always_comb begin
        win_data_s   = 64'd0;
        win_msg_s    = reset_SB_msg();
        win_onehot_s = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            win_onehot_s[k] = (win_id_s == 3'(k));
            win_data_s      = (win_id_s == 3'(k)) ? req_data_i[64*k +: 64] : win_data_s;
            win_msg_s       = (win_id_s == 3'(k)) ? req_msg_i[k] : win_msg_s;
        end
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_ptr_r    <= 3'(NUM_REQ - 1);
            cnt_r       <= {CNT_W{1'b0}};
            req_ready_o <= {NUM_REQ{1'b0}};
            dataBus_o   <= 64'd0;
            SB_msg_o    <= reset_SB_msg();
            valid_o     <= 1'b0;
            grant_id_o  <= 3'(NUM_REQ - 1);
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            timeout_o   <= 1'b0;
            req_ready_o <= {NUM_REQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (enable_i && send_next_flag_i && any_req_s) begin
                        dataBus_o   <= win_data_s;
                        SB_msg_o    <= win_msg_s;
                        req_ready_o <= win_onehot_s;
                        grant_id_o  <= win_id_s;
`ifdef SB_ARB_PRIO0_EN
                        rr_ptr_r    <= (win_id_s != 3'd0) ? win_id_s : rr_ptr_r;
`else
                        rr_ptr_r    <= win_id_s;
`endif
                        state_r     <= ISSUE;
                        busy_o      <= 1'b1;
                    end else begin
                        busy_o      <= 1'b0;
                    end
                end
                ISSUE: begin
                    valid_o <= 1'b1;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= WAIT_DROP;
                    busy_o  <= 1'b1;
                end
                WAIT_DROP: begin
                    if (!send_next_flag_i) begin
                        state_r <= WAIT_RDY;
                    end else if (cnt_r == CNT_W'(DROP_TIMEOUT - 1)) begin
                        // SB_TX never took the message; give the slot up rather than reissue
                        timeout_o <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= IDLE;
                        busy_o    <= 1'b0;
                    end else begin
                        cnt_r     <= cnt_r + CNT_W'(1);
                    end
                end
                WAIT_RDY: begin
                    if (send_next_flag_i) begin
                        state_r <= IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        busy_o  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter: grant order, handshake timing, timeout, enable and reset.
module tb_sb_tx_arbiter;
    import SB_codex_pkg::*;

    localparam int N = 3;

    logic            clk_100MHz = 1'b0;
    logic            reset;
    logic            enable_i;
    logic [N-1:0]    req_valid_i;
    logic [N*64-1:0] req_data_i;
    SB_msg_t         req_msg_i [N];
    logic [N-1:0]    req_ready_o;
    logic            send_next_flag_i;
    logic [63:0]     dataBus_o;
    SB_msg_t         SB_msg_o;
    logic            valid_o;
    logic [2:0]      grant_id_o;
    logic            busy_o;
    logic            timeout_o;

    logic [63:0]     tb_data [N];
    SB_msg_t         idle_msg;
    int              total = 0;
    int              bad = 0;
    int              valid_cnt = 0;
    int              base;

    sb_tx_arbiter #(.NUM_REQ(N), .DROP_TIMEOUT(16)) dut (
        .clk_100MHz       (clk_100MHz),
        .reset            (reset),
        .enable_i         (enable_i),
        .req_valid_i      (req_valid_i),
        .req_data_i       (req_data_i),
        .req_msg_i        (req_msg_i),
        .req_ready_o      (req_ready_o),
        .send_next_flag_i (send_next_flag_i),
        .dataBus_o        (dataBus_o),
        .SB_msg_o         (SB_msg_o),
        .valid_o          (valid_o),
        .grant_id_o       (grant_id_o),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(negedge clk_100MHz) begin
        if (valid_o) valid_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    // One full grant/issue/flag-drop/flag-rise cycle for the expected winner
    task automatic do_msg(input int exp_id, input string tag);
        logic [N-1:0] oh;
        oh = 3'b001 << exp_id;
        tick();
        check({tag, "_ready"}, 64'(req_ready_o), 64'(oh));
        check({tag, "_grant"}, 64'(grant_id_o), 64'(exp_id));
        tick();
        check({tag, "_valid"}, 64'(valid_o), 64'd1);
        check({tag, "_data"}, dataBus_o, tb_data[exp_id]);
        check({tag, "_msg"}, 64'(SB_msg_o), 64'(req_msg_i[exp_id]));
        send_next_flag_i = 1'b0;
        tick();
        check({tag, "_vdrop"}, 64'(valid_o), 64'd0);
        send_next_flag_i = 1'b1;
        tick();
        check({tag, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tb_data[0] = 64'h0123_4567_89AB_CDEF;
        tb_data[1] = 64'hCAFE_BABE_DEAD_BEEF;
        tb_data[2] = 64'h5A5A_A5A5_0F0F_F0F0;
        for (int k = 0; k < N; k++) begin
            req_data_i[64*k +: 64] = tb_data[k];
            req_msg_i[k]           = '{opcode: 5'(k + 2), srcid: 3'(k), dstid: 3'd5,
                                       msgcode: 8'(8'h40 + k), msgsubcode: 8'h11,
                                       msginfo: 16'(16'hBEE0 + k)};
        end
        idle_msg         = '{default: '0};
        idle_msg.opcode  = 5'h1F;
        reset            = 1'b0;
        enable_i         = 1'b1;
        req_valid_i      = 3'b000;
        send_next_flag_i = 1'b1;

        // Reset values
        do_reset();
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_data", dataBus_o, 64'd0);
        check("rst_msg", 64'(SB_msg_o), 64'(idle_msg));
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_grant", 64'(grant_id_o), 64'd2);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_tmo", 64'(timeout_o), 64'd0);

        // Single requester 1
        base = valid_cnt;
        req_valid_i = 3'b010;
        do_msg(1, "t1");
        req_valid_i = 3'b000;
        check("t1_vcount", 64'(valid_cnt - base), 64'd1);

        // All three held: round-robin (or strict prio 0)
        do_reset();
        base = valid_cnt;
        req_valid_i = 3'b111;
`ifdef SB_ARB_PRIO0_EN
        do_msg(0, "t2a"); do_msg(0, "t2b"); do_msg(0, "t2c"); do_msg(0, "t2d");
`else
        do_msg(0, "t2a"); do_msg(1, "t2b"); do_msg(2, "t2c"); do_msg(0, "t2d");
`endif
        req_valid_i = 3'b000;
        check("t2_vcount", 64'(valid_cnt - base), 64'd4);

        // Flag stuck high: timeout 16 cycles after ISSUE
        base = valid_cnt;
        req_valid_i = 3'b010;
        tick();
        check("t3_ready", 64'(req_ready_o), 64'b010);
        req_valid_i = 3'b000;
        tick();
        check("t3_valid", 64'(valid_o), 64'd1);
        repeat (15) tick();
        check("t3_tmo_early", 64'(timeout_o), 64'd0);
        check("t3_busy_wait", 64'(busy_o), 64'd1);
        tick();
        check("t3_tmo", 64'(timeout_o), 64'd1);
        check("t3_busy_idle", 64'(busy_o), 64'd0);
        tick();
        check("t3_tmo_pulse", 64'(timeout_o), 64'd0);
        check("t3_vcount", 64'(valid_cnt - base), 64'd1);

        // enable_i low blocks grants
        base = valid_cnt;
        enable_i = 1'b0;
        req_valid_i = 3'b100;
        repeat (3) tick();
        check("t4_noready", 64'(req_ready_o), 64'd0);
        check("t4_nobusy", 64'(busy_o), 64'd0);
        check("t4_novalid", 64'(valid_cnt - base), 64'd0);
        enable_i = 1'b1;
        do_msg(2, "t4");
        req_valid_i = 3'b000;

        // Reset while in WAIT_DROP
        req_valid_i = 3'b010;
        tick();
        req_valid_i = 3'b000;
        tick();
        tick();
        check("t5_busy_pre", 64'(busy_o), 64'd1);
        reset = 1'b1;
        req_valid_i = 3'b011;
        tick();
        reset = 1'b0;
        check("t5_valid", 64'(valid_o), 64'd0);
        check("t5_busy", 64'(busy_o), 64'd0);
        check("t5_grant", 64'(grant_id_o), 64'd2);
        check("t5_ready", 64'(req_ready_o), 64'd0);
        do_msg(0, "t5");

        // Requesters 0 and 1 held continuously
        base = valid_cnt;
`ifdef SB_ARB_PRIO0_EN
        do_msg(0, "t6a"); do_msg(0, "t6b"); do_msg(0, "t6c");
`else
        do_msg(1, "t6a"); do_msg(0, "t6b"); do_msg(1, "t6c");
`endif
        req_valid_i = 3'b000;
        check("t6_vcount", 64'(valid_cnt - base), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
